// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM encoding, requester IDs
// and default geometry.
package ram_arbiter_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 10;

    // FSM state encoding
    localparam logic StClear = 1'b0;
    localparam logic StRun   = 1'b1;

    // Requester IDs, also the encoding of the last-grant register
    localparam logic ReqA = 1'b0;
    localparam logic ReqB = 1'b1;

endpackage

// File: rtl/sp_sync_ram.sv
// Single-port synchronous RAM: registered read, one-cycle latency,
// read-before-write on a simultaneous access.
module sp_sync_ram
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    // Enabled access: q captures the old word, then the write lands
    always_ff @(posedge clk) begin
        if (en) begin
            q <= mem[addr];
            if (we) begin
                mem[addr] <= d;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM, with a
// full-RAM clear sequence run after reset and on request.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_d,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_d,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ClrLast = '1;

    logic                  state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  last_gnt_q;
    logic                  a_rvalid_q, b_rvalid_q;

    logic                  grant_ok;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_d, ram_q;

    // A clr pulse seen in RUN suppresses grants in the same cycle
    assign grant_ok = (state_q == StRun) && !clr;

    // Grant: sole requester wins; on a tie the one not granted last wins
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (grant_ok) begin
            if (a_req && b_req) begin
                if (last_gnt_q == ReqB) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // RAM port mux: clear sweep, else the granted requester
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        if (state_q == StClear) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
        end else if (a_gnt) begin
            ram_en   = 1'b1;
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_d    = a_d;
        end else if (b_gnt) begin
            ram_en   = 1'b1;
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_d    = b_d;
        end
    end

    // FSM and clear counter next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                if (clr) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == ClrLast) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State, counter, round-robin pointer and read-response pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            last_gnt_q <= ReqB;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (a_gnt) begin
                last_gnt_q <= ReqA;
            end else if (b_gnt) begin
                last_gnt_q <= ReqB;
            end
            a_rvalid_q <= a_gnt && !a_we;
            b_rvalid_q <= b_gnt && !b_we;
        end
    end

    sp_sync_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk (clk),
        .en  (ram_en),
        .we  (ram_we),
        .addr(ram_addr),
        .d   (ram_d),
        .q   (ram_q)
    );

    assign q        = ram_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a 16-word RAM: stimulus pushes the
// expected read responses, a negedge monitor pops and compares them.
module tb_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam logic        RA = 1'b0;
    localparam logic        RB = 1'b1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_d;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_d;
    logic [DW-1:0] q;
    logic          busy;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    ram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_d     (a_d),
        .a_gnt   (a_gnt),
        .a_rvalid(a_rvalid),
        .b_req   (b_req),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_d     (b_d),
        .b_gnt   (b_gnt),
        .b_rvalid(b_rvalid),
        .q       (q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic who, input logic [DW-1:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: every rvalid must match the oldest expected response
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (a_rvalid || b_rvalid)) begin
            if (a_rvalid && b_rvalid) begin
                check("rvalid_both", {a_rvalid, b_rvalid}, 2'b00);
            end else if (sb.size() == 0) begin
                check("rvalid_unexpected", {a_rvalid, b_rvalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid_who", {31'd0, b_rvalid}, {31'd0, e.who});
                check("rvalid_q", {24'd0, q}, {24'd0, e.data});
                check("rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    // Single request; must be granted in the cycle it is raised
    task automatic issue(input string name, input logic who, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp);
        if (who == RA) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_d = d;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_d = d;
        end
        #1;
        check(name, {a_gnt, b_gnt}, (who == RA) ? 2'b10 : 2'b01);
        if (!we && ((who == RA) ? a_gnt : b_gnt)) push(who, exp);
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // Count busy cycles from now; optionally re-pulse clr after restart_at
    task automatic count_busy(input string name, input int restart_at, input int exp_n);
        int n   = 0;
        int bad = 0;
        forever begin
            #1;
            if (!busy || n >= 200) break;
            if (a_gnt || b_gnt) bad++;
            n++;
            if (restart_at != 0 && n == restart_at) clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end
        check(name, n, exp_n);
        check({name, "_no_gnt"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clr = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_d = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_d = '0;
        repeat (3) @(negedge clk);

        // Reset state, with a request present that must not be granted
        a_req = 1'b1; b_req = 1'b1;
        #1;
        check("rst_busy", busy, 1);
        check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        count_busy("busy_after_reset", 0, 16);

        // Cleared RAM, write then read back, write-only gives no rvalid
        issue("a_rd3_gnt", RA, 1'b0, 4'd3, 8'h00, 8'h00);
        issue("a_wr5_gnt", RA, 1'b1, 4'd5, 8'hA5, 8'h00);
        issue("a_rd5_gnt", RA, 1'b0, 4'd5, 8'h00, 8'hA5);
        issue("a_wr1_gnt", RA, 1'b1, 4'd1, 8'h11, 8'h00);
        issue("b_wr2_gnt", RB, 1'b1, 4'd2, 8'h22, 8'h00);

        // Both hold reads: last grant was B, so A,B,A,B,...
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_gnt", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i % 2 == 0) push(RA, 8'h11);
            else            push(RB, 8'h22);
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;

        // A granted alone, then a tie must go to B
        issue("a_rd1_gnt", RA, 1'b0, 4'd1, 8'h00, 8'h11);
        a_req = 1'b1; b_req = 1'b1;
        #1;
        check("tie_after_a", {a_gnt, b_gnt}, 2'b01);
        push(RB, 8'h22);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;

        // B write 7, B read 2, then clr with A holding a read of 7
        issue("b_wr7_gnt", RB, 1'b1, 4'd7, 8'h3C, 8'h00);
        issue("b_rd2_gnt", RB, 1'b0, 4'd2, 8'h00, 8'h22);
        clr = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7;
        #1;
        check("clr_cycle_gnt", {a_gnt, b_gnt}, 2'b00);
        @(negedge clk);
        clr = 1'b0;
        count_busy("busy_after_clr", 0, 16);
        check("held_a_gnt", {a_gnt, b_gnt}, 2'b10);
        push(RA, 8'h00);
        @(negedge clk);
        a_req = 1'b0;

        // clr during a clear restarts the sweep
        issue("a_wr9_gnt", RA, 1'b1, 4'd9, 8'h99, 8'h00);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        count_busy("busy_restart", 5, 21);
        issue("a_rd9_gnt", RA, 1'b0, 4'd9, 8'h00, 8'h00);

        // Reset right after a granted B read drops the response
        issue("a_wr4_gnt", RA, 1'b1, 4'd4, 8'h44, 8'h00);
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd4;
        #1;
        check("b_rd4_gnt", {a_gnt, b_gnt}, 2'b01);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        b_req = 1'b0;
        #1;
        check("rst_drop_rvalid", b_rvalid, 0);
        check("rst_drop_busy", busy, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_busy("busy_after_reset2", 0, 16);
        issue("a_rd4_gnt", RA, 1'b0, 4'd4, 8'h00, 8'h00);
        issue("b_rd5_gnt", RB, 1'b0, 4'd5, 8'h00, 8'h00);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the RAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, is the RAM address width; depth is 2**ADDR_WIDTH words.
REQ-003 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 clr  input  1  one-cycle pulse that requests a full RAM clear.
REQ-007 a_req  input  1  requester A access request.
REQ-008 a_we  input  1  requester A: 1 = write, 0 = read.
REQ-009 a_addr  input  ADDR_WIDTH  requester A address.
REQ-010 a_d  input  DATA_WIDTH  requester A write data.
REQ-011 a_gnt  output  1  requester A access accepted this cycle.
REQ-012 a_rvalid  output  1  q holds requester A read data this cycle.
REQ-013 b_req, b_we, b_addr, b_d, b_gnt, b_rvalid: same directions, widths and meanings as the A ports, for requester B.
REQ-014 q  output  DATA_WIDTH  shared read data; defined only while a_rvalid or b_rvalid is 1.
REQ-015 busy  output  1  clear in progress; no grants are issued.

Function
REQ-016 Two-state FSM: CLEAR and RUN.
REQ-017 In CLEAR: write 0 to address clr_cnt each cycle, clr_cnt counting 0 to 2**ADDR_WIDTH-1; busy=1; a_gnt=b_gnt=0.
REQ-018 CLEAR -> RUN on the cycle after clr_cnt = 2**ADDR_WIDTH-1 is written; a clear takes exactly 2**ADDR_WIDTH cycles.
REQ-019 In RUN, clr=1 -> CLEAR on the next edge with clr_cnt=0; no grant is issued in the cycle clr is sampled.
REQ-020 clr=1 while in CLEAR restarts clr_cnt at 0.
REQ-021 In RUN, grants are combinational in the request cycle; at most one grant per cycle.
REQ-022 Only one requester asserting req: that requester is granted.
REQ-023 Both requesters asserting req: round-robin; grant goes to the requester not granted last; last_gnt updates on every grant.
REQ-024 A granted access drives the RAM with the granted requester's we, addr and d that cycle.
REQ-025 A granted read asserts the requester's rvalid exactly 1 cycle later, with q = RAM word; a granted write produces no rvalid.
REQ-026 Back-to-back reads from either requester are sustained at one per cycle; rvalid routing follows the requester granted in the previous cycle.
REQ-027 A read on the cycle after a write to the same address returns the newly written data.
REQ-028 A requester holds req, we, addr and d until it sees its gnt; ungranted requests are not queued internally.
REQ-029 Any rvalid due in the cycle after clr is sampled is still delivered.

Reset
REQ-030 While reset_n=0: state=CLEAR, clr_cnt=0, last_gnt=B (A wins the first tie), a_rvalid=b_rvalid=0, a_gnt=b_gnt=0, busy=1.
REQ-031 Reset asserted mid-operation drops any pending read response immediately; q is undefined until the next rvalid.
REQ-032 After reset_n deasserts, the block performs a full clear before entering RUN.

Structure
REQ-033 A shared package holds the FSM state encoding, the requester IDs (A=0, B=1) and the default DATA_WIDTH/ADDR_WIDTH values.
REQ-034 There is one sub-module, sp_sync_ram: single-port synchronous RAM with a registered read, 1-cycle latency and read-before-write, instantiated once.
REQ-035 The arbiter, clear counter and rvalid pipeline registers live in ram_arbiter.

Verification (benches use ADDR_WIDTH=4, 16 words)
REQ-036 Release reset -> busy=1 for exactly 16 cycles, then 0; A reads addr 3 -> a_rvalid after 1 cycle with q=0x00.
REQ-037 A writes 0xA5 to addr 5, next cycle A reads addr 5 -> a_rvalid=1 the following cycle with q=0xA5; b_rvalid stays 0.
REQ-038 a_req and b_req held high with reads -> gnt sequence A,B,A,B,...; rvalids alternate one cycle behind; q matches each requester's address.
REQ-039 B writes 0x3C to addr 7, then clr pulse with a_req held high -> a_gnt=0 for 16 cycles; afterwards a read of addr 7 returns 0x00.
REQ-040 reset_n driven low the cycle after a granted B read -> b_rvalid=0 and busy=1 immediately without a clock edge; a full 16-cycle clear follows release.
